rock_level_controller: RTL
==========================

// Module: rock_level_controller
// PURPOSE
//  Parametrised successor of the baby-rocking level controller. Runs on the
//  system clock, not on a derived stress pulse, and evaluates one decision per
//  tick pulse (from the stress detector's one-tick stage).
//  Walks the freq/amp rocking levels up under stress and down after sustained
//  calm. Flags a sticky error when maximum rocking cannot calm the baby.
//  Sits between the stress input block and the output (PSfreq/PSamp) generator.
// PARAMETERS
//  LVL_W       3  width of freq/amp level codes
//  MAX_LVL     7  highest level per axis (must be <= 2**LVL_W-1, >= 1)
//  HOLD_TICKS  4  consecutive calm ticks required per step down (>= 1)
//  ESC_MAX     3  consecutive stressed ticks at (MAX_LVL,MAX_LVL) before error (>= 1)
//  FREQ_FIRST  1  1: freq leads on escalation and amp leads on de-escalation; 0: mirrored
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  tick        in   1      one-cycle evaluation strobe; all inputs ignored when 0
//  stress_low  in   1      level, sampled on tick: 1 = calm, 0 = stressed
//  clear_err   in   1      one-cycle pulse; leaves ERROR state
//  freq        out  LVL_W  rocking frequency level (registered)
//  amp         out  LVL_W  rocking amplitude level (registered)
//  error       out  1      sticky error flag (registered)
//  state_o     out  2      0 IDLE, 1 ROCK, 2 ERROR
//  lvl_upd     out  1      1-cycle pulse when freq or amp changed this cycle
// BEHAVIOUR
//  Reset: freq=0, amp=0, error=0, state=IDLE, lvl_upd=0, calm_cnt=0, esc_cnt=0.
//  Reset has priority over every other input, including mid-operation.
//  Latency: tick on cycle N -> outputs hold the new values from cycle N+1.
//  lvl_upd is high on cycle N+1 only if a level changed.
//  Step up (stressed tick, not at max):
//    FREQ_FIRST=1: if freq<=amp then freq+1, else amp+1.
//    Saturate one axis at MAX_LVL and push the other.
//  Step down (calm step):
//    FREQ_FIRST=1: if freq>amp then freq-1, else amp-1.
//    Never decrement below 0.
//  FREQ_FIRST=0 swaps the roles of freq and amp in both rules.
//  IDLE:
//    Calm tick: no change.
//    Stressed tick: step up, go to ROCK, calm_cnt=0.
//  ROCK, stressed tick:
//    calm_cnt=0.
//    Not at (MAX,MAX): step up, esc_cnt=0.
//    At (MAX,MAX): esc_cnt+1. When esc_cnt reaches ESC_MAX: go to ERROR,
//      freq=amp=0, error=1, lvl_upd=1.
//  ROCK, calm tick:
//    esc_cnt=0 and calm_cnt+1.
//    When calm_cnt reaches HOLD_TICKS: step down and calm_cnt=0.
//    If that step reaches (0,0): go to IDLE.
//  ERROR:
//    freq=amp=0 and error=1; ticks are ignored.
//    clear_err -> IDLE, error=0, counters=0.
//  clear_err outside ERROR: no effect.
//  clear_err and tick in the same cycle while in ERROR: clear wins, the tick
//    is discarded, and the next tick is evaluated from IDLE.
//  Counter widths: calm_cnt and esc_cnt use clog2(param+1) bits and never wrap.
//    Both reset to 0 on every step and on every state change.
//  state_o encoding 3 is unused. Treat it as illegal; it recovers to IDLE on
//    the next clock.
// TESTING (defaults)
//  T1 Escalation: reset, 3 stressed ticks -> (freq,amp) = (1,0),(1,1),(2,1),
//     lvl_upd pulses each cycle N+1, state=ROCK.
//  T2 Error: 14 stressed ticks -> (7,7), then 3 more -> error=1, freq=amp=0,
//     state=2. Further ticks -> no change.
//  T3 De-escalation: from (2,1), 4 calm ticks -> (1,1); 4 more -> (1,0);
//     4 more -> (0,0) with state=IDLE. lvl_upd fires only on the 4th tick of each group.
//  T4 Calm interrupt: from (1,1), 3 calm ticks, then 1 stressed, then 3 calm
//     -> (2,1), with no step down. The stressed tick reset calm_cnt.
//  T5 Clear race: in ERROR, assert clear_err and a stressed tick in the same
//     cycle -> IDLE, (0,0), error=0. The next stressed tick -> (1,0).
//  T6 Reset mid-op: at (5,4) with calm_cnt=2, pulse reset -> all outputs 0
//     next cycle. Then 4 calm ticks -> no change (IDLE).

Source files
------------

// File: rtl/rock_level_controller_if.sv
// Bundles the tick-domain inputs and the level outputs of rock_level_controller.
// The master drives tick/stress/clear and observes the levels; the slave is the controller.
interface rock_level_controller_if #(
    parameter int unsigned LVL_W = 3
) ();
    logic             tick;
    logic             stress_low;
    logic             clear_err;
    logic [LVL_W-1:0] freq;
    logic [LVL_W-1:0] amp;
    logic             error;
    logic [1:0]       state_o;
    logic             lvl_upd;

    modport master (
        output tick, stress_low, clear_err,
        input  freq, amp, error, state_o, lvl_upd
    );

    modport slave (
        input  tick, stress_low, clear_err,
        output freq, amp, error, state_o, lvl_upd
    );
endinterface

// File: rtl/rock_level_controller.sv
// Walks freq/amp rocking levels up under stress and down after sustained calm,
// one decision per tick, with a sticky error when maximum rocking fails.
module rock_level_controller #(
    parameter int unsigned LVL_W      = 3,
    parameter int unsigned MAX_LVL    = 7,
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned ESC_MAX    = 3,
    parameter int unsigned FREQ_FIRST = 1
) (
    input logic                  clk,
    input logic                  reset,
    rock_level_controller_if.slave bus
);
    localparam int unsigned CalmW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned EscW  = $clog2(ESC_MAX + 1);
    localparam logic [LVL_W-1:0] MaxLvl   = LVL_W'(MAX_LVL);
    localparam logic [CalmW-1:0] CalmLast = CalmW'(HOLD_TICKS - 1);
    localparam logic [EscW-1:0]  EscLast  = EscW'(ESC_MAX - 1);

    typedef enum logic [1:0] {StIdle = 2'd0, StRock = 2'd1, StError = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [LVL_W-1:0] freq_q, freq_d, amp_q, amp_d;
    logic [CalmW-1:0] calm_q, calm_d;
    logic [EscW-1:0]  esc_q, esc_d;
    logic             error_q, error_d, upd_q, upd_d;

    // lead is the axis favoured by the step rules; FREQ_FIRST=0 mirrors freq and amp
    logic [LVL_W-1:0] lead, oth, lead_up, oth_up, lead_dn, oth_dn;
    logic [LVL_W-1:0] up_f, up_a, dn_f, dn_a;
    logic             at_max;

    always_comb begin
        lead    = (FREQ_FIRST != 0) ? freq_q : amp_q;
        oth     = (FREQ_FIRST != 0) ? amp_q : freq_q;
        lead_up = lead;
        oth_up  = oth;
        lead_dn = lead;
        oth_dn  = oth;
        if (((lead <= oth) && (lead != MaxLvl)) || (oth == MaxLvl)) begin
            lead_up = lead + 1'b1;
        end else begin
            oth_up = oth + 1'b1;
        end
        if (lead > oth) begin
            lead_dn = lead - 1'b1;
        end else if (oth != '0) begin
            oth_dn = oth - 1'b1;
        end
        up_f   = (FREQ_FIRST != 0) ? lead_up : oth_up;
        up_a   = (FREQ_FIRST != 0) ? oth_up : lead_up;
        dn_f   = (FREQ_FIRST != 0) ? lead_dn : oth_dn;
        dn_a   = (FREQ_FIRST != 0) ? oth_dn : lead_dn;
        at_max = (freq_q == MaxLvl) && (amp_q == MaxLvl);
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        calm_d  = calm_q;
        esc_d   = esc_q;
        case (state_q)
            StIdle: begin
                if (bus.tick && !bus.stress_low) begin
                    freq_d  = up_f;
                    amp_d   = up_a;
                    state_d = StRock;
                    calm_d  = '0;
                    esc_d   = '0;
                end
            end
            StRock: begin
                if (bus.tick && !bus.stress_low) begin
                    calm_d = '0;
                    if (!at_max) begin
                        freq_d = up_f;
                        amp_d  = up_a;
                        esc_d  = '0;
                    end else if (esc_q == EscLast) begin
                        state_d = StError;
                        freq_d  = '0;
                        amp_d   = '0;
                        esc_d   = '0;
                    end else begin
                        esc_d = esc_q + 1'b1;
                    end
                end else if (bus.tick) begin
                    esc_d = '0;
                    if (calm_q == CalmLast) begin
                        freq_d = dn_f;
                        amp_d  = dn_a;
                        calm_d = '0;
                        if ((dn_f == '0) && (dn_a == '0)) begin
                            state_d = StIdle;
                        end
                    end else begin
                        calm_d = calm_q + 1'b1;
                    end
                end
            end
            StError: begin
                freq_d = '0;
                amp_d  = '0;
                // clear wins over a same-cycle tick, which is simply dropped
                if (bus.clear_err) begin
                    state_d = StIdle;
                    calm_d  = '0;
                    esc_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                freq_d  = '0;
                amp_d   = '0;
                calm_d  = '0;
                esc_d   = '0;
            end
        endcase
        error_d = (state_d == StError);
        upd_d   = (freq_d != freq_q) || (amp_d != amp_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            freq_q  <= '0;
            amp_q   <= '0;
            calm_q  <= '0;
            esc_q   <= '0;
            error_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            calm_q  <= calm_d;
            esc_q   <= esc_d;
            error_q <= error_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.freq    = freq_q;
    assign bus.amp     = amp_q;
    assign bus.error   = error_q;
    assign bus.state_o = state_q;
    assign bus.lvl_upd = upd_q;
endmodule
